// File: rtl/clock_enable_sequencer_if.sv
// -----------------------------------------------------------------------------
// clock_enable_sequencer_if
// Bundles the lock/rate/hold inputs and the enable/reset outputs of the
// clock enable sequencer.
//   locked    : DCM LOCKED, asynchronous to the system clock
//   turbo     : requested CPU rate (0=3.5, 1=7, 2/3=14 MHz)
//   cpu_hold  : contention/wait request, suppresses CPU rising enables
//   rst_out   : synchronous system reset, high until the sequencer runs
//   ce7p/ce7n : 7 MHz pixel enables, rising/falling phase
//   cpu_cep/cpu_cen : CPU enables, rising/falling phase
//   psg_ce    : 1.75 MHz audio enable
//   turbo_ack : CPU rate currently applied
// slave modport faces the sequencer, master modport faces the system.
// -----------------------------------------------------------------------------
interface clock_enable_sequencer_if;
    logic       locked;
    logic [1:0] turbo;
    logic       cpu_hold;
    logic       rst_out;
    logic       ce7p;
    logic       ce7n;
    logic       cpu_cep;
    logic       cpu_cen;
    logic       psg_ce;
    logic [1:0] turbo_ack;

    modport slave (
        input  locked, turbo, cpu_hold,
        output rst_out, ce7p, ce7n, cpu_cep, cpu_cen, psg_ce, turbo_ack
    );

    modport master (
        output locked, turbo, cpu_hold,
        input  rst_out, ce7p, ce7n, cpu_cep, cpu_cen, psg_ce, turbo_ack
    );
endinterface

// File: rtl/clock_enable_sequencer.sv
// -----------------------------------------------------------------------------
// clock_enable_sequencer
// Owns the 28.333 MHz DCM clock domain. Holds the system in reset until DCM
// lock has been stable for STARTUP_CYCLES clocks, then derives all clock
// enables (pixel, CPU, PSG) from one 5-bit phase counter. CPU rate changes
// are applied only at 8-phase boundaries and CPU rising enables can be held
// off by cpu_hold; a started CPU cycle always completes.
// Ports:
//   clock : system clock from the DCM CLKFX buffer
//   reset : asynchronous, active-high reset
//   bus   : slave side of clock_enable_sequencer_if (see interface header)
// -----------------------------------------------------------------------------
module clock_enable_sequencer #(
    parameter int STARTUP_CYCLES = 1024
) (
    input  logic                            clock,
    input  logic                            reset,
    clock_enable_sequencer_if.slave         bus
);
    localparam int CW = (STARTUP_CYCLES > 2) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(STARTUP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STARTUP   = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    logic          r_lock_meta;
    logic          r_lock_sync;
    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic [4:0]    r_phase;
    logic [4:0]    w_phase_next;
    logic [1:0]    r_ack;
    logic [1:0]    w_ack_next;
    logic          r_half;
    logic          w_half_next;
    logic          w_run_next;
    logic          w_switch;
    logic [1:0]    w_turbo_sat;
    logic          w_raw_p;
    logic          w_raw_n;
    logic          w_cep_next;
    logic          w_cen_next;
    logic          r_rst_out;
    logic          r_ce7p;
    logic          r_ce7n;
    logic          r_cpu_cep;
    logic          r_cpu_cen;
    logic          r_psg_ce;

    // Two-flop synchroniser for the asynchronous DCM lock signal
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= bus.locked;
            r_lock_sync <= r_lock_meta;
        end
    end

    // FSM state and startup counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_WAIT_LOCK;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // FSM next-state: lock must stay high for the whole startup window
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            S_WAIT_LOCK: begin
                w_count_next = '0;
                if (r_lock_sync) begin
                    w_state_next = S_STARTUP;
                end else begin
                    w_state_next = S_WAIT_LOCK;
                end
            end
            S_STARTUP: begin
                if (!r_lock_sync) begin
                    w_state_next = S_WAIT_LOCK;
                    w_count_next = '0;
                end else if (r_count == COUNT_LAST) begin
                    w_state_next = S_RUN;
                end else begin
                    w_count_next = r_count + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_RUN: begin
                if (!r_lock_sync) begin
                    w_state_next = S_WAIT_LOCK;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_WAIT_LOCK;
                w_count_next = '0;
            end
        endcase
    end

    // Enable decode; all enables are computed for the next phase so the
    // registered outputs line up with the phase they belong to.
    always_comb begin
        w_run_next  = (w_state_next == S_RUN);
        w_phase_next = 5'd0;
        if (w_run_next && (r_state == S_RUN)) begin
            w_phase_next = r_phase + 5'd1;
        end else begin
            w_phase_next = 5'd0;
        end

        // Rate changes land only after the phase-7 falling enable, so the
        // new rate starts cleanly at phase 0 of the next 8-phase group.
        w_turbo_sat = (bus.turbo == 2'd3) ? 2'd2 : bus.turbo;
        w_switch    = (r_state == S_RUN) && (r_phase[2:0] == 3'd7);
        w_ack_next  = w_switch ? w_turbo_sat : r_ack;

        case (w_ack_next)
            2'd0: begin
                w_raw_p = (w_phase_next[2:0] == 3'd3);
                w_raw_n = (w_phase_next[2:0] == 3'd7);
            end
            2'd1: begin
                w_raw_p = (w_phase_next[1:0] == 2'd1);
                w_raw_n = (w_phase_next[1:0] == 2'd3);
            end
            default: begin
                w_raw_p = (w_phase_next[0] == 1'b0);
                w_raw_n = (w_phase_next[0] == 1'b1);
            end
        endcase

        // Rising enable may be held off; falling enable only closes an
        // already-open CPU cycle, which keeps p/n strictly alternating.
        w_cep_next = w_run_next && w_raw_p && !bus.cpu_hold && !r_half;
        w_cen_next = w_run_next && w_raw_n && r_half;

        if (!w_run_next) begin
            w_half_next = 1'b0;
        end else if (w_cep_next) begin
            w_half_next = 1'b1;
        end else if (w_cen_next) begin
            w_half_next = 1'b0;
        end else begin
            w_half_next = r_half;
        end
    end

    // Phase, rate, pairing and registered enable outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase   <= 5'd0;
            r_ack     <= 2'd0;
            r_half    <= 1'b0;
            r_rst_out <= 1'b1;
            r_ce7p    <= 1'b0;
            r_ce7n    <= 1'b0;
            r_cpu_cep <= 1'b0;
            r_cpu_cen <= 1'b0;
            r_psg_ce  <= 1'b0;
        end else begin
            r_phase   <= w_phase_next;
            r_ack     <= w_ack_next;
            r_half    <= w_half_next;
            r_rst_out <= !w_run_next;
            r_ce7p    <= w_run_next && (w_phase_next[1:0] == 2'd1);
            r_ce7n    <= w_run_next && (w_phase_next[1:0] == 2'd3);
            r_cpu_cep <= w_cep_next;
            r_cpu_cen <= w_cen_next;
            r_psg_ce  <= w_run_next && (w_phase_next[3:0] == 4'd15);
        end
    end

    assign bus.rst_out   = r_rst_out;
    assign bus.ce7p      = r_ce7p;
    assign bus.ce7n      = r_ce7n;
    assign bus.cpu_cep   = r_cpu_cep;
    assign bus.cpu_cen   = r_cpu_cen;
    assign bus.psg_ce    = r_psg_ce;
    assign bus.turbo_ack = r_ack;

endmodule

// File: tb/tb_clock_enable_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clock_enable_sequencer
// Self-checking bench for clock_enable_sequencer. A behavioural model tracks
// how long lock has been seen stable, the phase within RUN, the applied rate
// and whether a CPU cycle is open, and predicts every output each clock.
// -----------------------------------------------------------------------------
module tb_clock_enable_sequencer;
    localparam int N = 1024;

    logic clk;
    logic reset;
    clock_enable_sequencer_if bus ();

    clock_enable_sequencer #(.STARTUP_CYCLES(N)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    bit         m_lk1, m_lk2;
    int         m_streak;
    bit         m_run;
    int         m_phase;
    logic [1:0] m_ack;
    bit         m_mid;
    logic [7:0] m_exp;

    function automatic logic [7:0] dut_vec();
        return {bus.rst_out, bus.ce7p, bus.ce7n, bus.cpu_cep, bus.cpu_cen,
                bus.psg_ce, bus.turbo_ack};
    endfunction

    task automatic model_clear();
        m_lk1 = 1'b0; m_lk2 = 1'b0; m_streak = 0; m_run = 1'b0;
        m_phase = 0; m_ack = 2'd0; m_mid = 1'b0; m_exp = 8'b1000_0000;
    endtask

    // Predict the outputs after the next rising edge, then advance to #1 past it.
    task automatic tick();
        bit vis, was_run, ep, en;
        int prev, per;
        if (reset) begin
            model_clear();
        end else begin
            vis = m_lk2; m_lk2 = m_lk1; m_lk1 = bus.locked;
            was_run = m_run; prev = m_phase;
            m_streak = vis ? ((m_streak <= N) ? m_streak + 1 : m_streak) : 0;
            m_run = (m_streak > N);
            if (was_run && (prev % 8 == 7))
                m_ack = (bus.turbo > 2'd2) ? 2'd2 : bus.turbo;
            m_phase = m_run ? (was_run ? (prev + 1) % 32 : 0) : 0;
            per = 8 >> m_ack;
            ep = m_run && (m_phase % per == per / 2 - 1) && !bus.cpu_hold && !m_mid;
            en = m_run && (m_phase % per == per - 1) && m_mid;
            if (!m_run) m_mid = 1'b0;
            else if (ep) m_mid = 1'b1;
            else if (en) m_mid = 1'b0;
            m_exp = {!m_run, m_run && (m_phase % 4 == 1), m_run && (m_phase % 4 == 3),
                     ep, en, m_run && (m_phase % 16 == 15), m_ack};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        for (int i = 0; i < 6; i++) begin
            bus.locked = (i >= 3);
            tick();
            v = dut_vec();
            n_vec++;
            if (v !== m_exp || v !== 8'b1000_0000) begin
                n_err++;
                $display("FAIL reset cyc %0d got %b want %b", i, v, m_exp);
            end
        end
        bus.locked = 1'b0;
    endtask

    task automatic test_startup();
        logic [7:0] v;
        int cnt;
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            v = dut_vec();
            n_vec++;
            if (v !== m_exp) begin
                n_err++;
                $display("FAIL startup_unlocked cyc %0d got %b want %b", i, v, m_exp);
            end
        end
        bus.locked = 1'b1;
        cnt = 0;
        while (bus.rst_out !== 1'b0 && cnt < N + 20) begin
            tick();
            cnt++;
            v = dut_vec();
            n_vec++;
            if (v !== m_exp) begin
                n_err++;
                $display("FAIL startup_wait cyc %0d got %b want %b", cnt, v, m_exp);
            end
        end
        n_vec++;
        if (cnt !== N + 3) begin
            n_err++;
            $display("FAIL startup_latency got %0d clocks want %0d", cnt, N + 3);
        end
    endtask

    task automatic test_free_run();
        logic [7:0] v;
        int n_p, n_n, n_7p, n_7n, n_psg;
        n_p = 0; n_n = 0; n_7p = 0; n_7n = 0; n_psg = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            v = dut_vec();
            n_vec++;
            if (v !== m_exp) begin
                n_err++;
                $display("FAIL free_run phase %0d got %b want %b", m_phase, v, m_exp);
            end
            if (i >= 32) begin
                n_p += int'(bus.cpu_cep); n_n += int'(bus.cpu_cen);
                n_7p += int'(bus.ce7p); n_7n += int'(bus.ce7n); n_psg += int'(bus.psg_ce);
            end
        end
        n_vec++;
        if (n_p !== 4 || n_n !== 4 || n_7p !== 8 || n_7n !== 8 || n_psg !== 2) begin
            n_err++;
            $display("FAIL free_run_counts got p%0d n%0d 7p%0d 7n%0d psg%0d want 4 4 8 8 2",
                     n_p, n_n, n_7p, n_7n, n_psg);
        end
    endtask

    task automatic test_turbo_switch();
        logic [7:0] v;
        int guard;
        bit last_p, seen;
        guard = 0;
        while (m_phase != 8 && guard < 40) begin
            tick(); guard++;
        end
        bus.turbo = 2'd2;
        for (int i = 0; i < 24; i++) begin
            tick();
            v = dut_vec();
            n_vec++;
            if (v !== m_exp) begin
                n_err++;
                $display("FAIL turbo_0to2 phase %0d got %b want %b", m_phase, v, m_exp);
            end
            if (m_phase == 16) begin
                n_vec++;
                if (bus.turbo_ack !== 2'd2 || bus.cpu_cep !== 1'b1) begin
                    n_err++;
                    $display("FAIL turbo_ack_at16 got ack %0d cep %b want 2 1",
                             bus.turbo_ack, bus.cpu_cep);
                end
            end
        end
        seen = 1'b0; last_p = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15, 0) == 0) bus.turbo = 2'($urandom_range(3, 0));
            bus.cpu_hold = ($urandom_range(5, 0) == 0);
            tick();
            v = dut_vec();
            n_vec++;
            if (v !== m_exp) begin
                n_err++;
                $display("FAIL turbo_random cyc %0d got %b want %b", i, v, m_exp);
            end
            if (bus.cpu_cep || bus.cpu_cen) begin
                n_vec++;
                if ((bus.cpu_cep && bus.cpu_cen) || (seen && (last_p == bus.cpu_cep))) begin
                    n_err++;
                    $display("FAIL alternation cyc %0d got p%b n%b after last_p %b",
                             i, bus.cpu_cep, bus.cpu_cen, last_p);
                end
                seen = 1'b1; last_p = bus.cpu_cep;
            end
        end
        bus.cpu_hold = 1'b0;
    endtask

    task automatic test_hold();
        logic [7:0] v;
        int guard;
        bus.turbo = 2'd1;
        guard = 0;
        while (!(m_phase == 3 && m_ack == 2'd1) && guard < 80) begin
            tick(); guard++;
        end
        for (int i = 0; i < 16; i++) begin
            bus.cpu_hold = (m_phase >= 3 && m_phase <= 11);
            tick();
            v = dut_vec();
            n_vec++;
            if (v !== m_exp) begin
                n_err++;
                $display("FAIL hold phase %0d got %b want %b", m_phase, v, m_exp);
            end
            if (m_phase >= 4 && m_phase <= 12) begin
                n_vec++;
                if (bus.cpu_cep !== 1'b0) begin
                    n_err++;
                    $display("FAIL hold_cep phase %0d got %b want 0", m_phase, bus.cpu_cep);
                end
            end
            if (m_phase == 13 || m_phase == 15) begin
                n_vec++;
                if ((m_phase == 13 && bus.cpu_cep !== 1'b1) || (m_phase == 15 && bus.cpu_cen !== 1'b1)) begin
                    n_err++;
                    $display("FAIL hold_resume phase %0d got p%b n%b want issued",
                             m_phase, bus.cpu_cep, bus.cpu_cen);
                end
            end
        end
        bus.cpu_hold = 1'b0;
    endtask

    task automatic test_lock_drop();
        logic [7:0] v;
        int cnt;
        bus.locked = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            v = dut_vec();
            n_vec++;
            if (v !== m_exp) begin
                n_err++;
                $display("FAIL lock_drop cyc %0d got %b want %b", i, v, m_exp);
            end
        end
        n_vec++;
        if (bus.rst_out !== 1'b1 || v[6:2] !== 5'd0) begin
            n_err++;
            $display("FAIL lock_drop_reset got %b want rst 1 ce 0", v);
        end
        bus.locked = 1'b1;
        cnt = 0;
        while (bus.rst_out !== 1'b0 && cnt < N + 20) begin
            tick();
            cnt++;
            v = dut_vec();
            n_vec++;
            if (v !== m_exp) begin
                n_err++;
                $display("FAIL relock cyc %0d got %b want %b", cnt, v, m_exp);
            end
        end
        n_vec++;
        if (cnt !== N + 3) begin
            n_err++;
            $display("FAIL relock_latency got %0d clocks want %0d", cnt, N + 3);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            v = dut_vec();
            n_vec++;
            if (v !== m_exp) begin
                n_err++;
                $display("FAIL relock_run cyc %0d got %b want %b", i, v, m_exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] v;
        logic [7:0] rst_vec;
        rst_vec = 8'b1000_0000;
        #3;
        reset = 1'b1;
        #1;
        model_clear();
        v = dut_vec();
        n_vec++;
        if (v !== rst_vec) begin
            n_err++;
            $display("FAIL async_reset got %b want %b", v, rst_vec);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            v = dut_vec();
            n_vec++;
            if (v !== m_exp) begin
                n_err++;
                $display("FAIL async_reset_hold cyc %0d got %b want %b", i, v, m_exp);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            v = dut_vec();
            n_vec++;
            if (v !== m_exp) begin
                n_err++;
                $display("FAIL after_reset cyc %0d got %b want %b", i, v, m_exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.locked = 1'b0;
        bus.turbo = 2'd0;
        bus.cpu_hold = 1'b0;
        model_clear();
        test_reset();
        test_startup();
        test_free_run();
        test_turbo_switch();
        test_hold();
        test_lock_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
